// File: rtl/noc_inject_packetizer_if.sv
// rtl/noc_inject_packetizer_if.sv - core request and NoC packet handshake bundle
//
// Purpose: groups the core-side request channel and the bridge-side packet
// channel of the injection packetizer.
//   in_valid/in_ready          request handshake (core -> packetizer)
//   in_dest/in_type/in_tag/in_data  request fields
//   pkt_valid/pkt_ready        packet handshake (packetizer -> bridge)
//   pkt_data                   33-bit NoC packet
// Modports: master = core/bridge side, slave = packetizer side.
interface noc_inject_packetizer_if #(
  parameter int WIDTH_PACKAGE = 33
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [4:0]               in_dest;
  logic [1:0]               in_type;
  logic [4:0]               in_tag;
  logic [15:0]              in_data;
  logic                     pkt_valid;
  logic                     pkt_ready;
  logic [WIDTH_PACKAGE-1:0] pkt_data;

  modport master (
    output in_valid, in_dest, in_type, in_tag, in_data, pkt_ready,
    input  in_ready, pkt_valid, pkt_data
  );

  modport slave (
    input  in_valid, in_dest, in_type, in_tag, in_data, pkt_ready,
    output in_ready, pkt_valid, pkt_data
  );
endinterface

// File: rtl/noc_inject_packetizer.sv
// rtl/noc_inject_packetizer.sv - core-to-NoC injection packetizer with packet FIFO
//
// Purpose: validates core request destinations against the torus, builds
// {dest, src, type, tag, data} packets and queues them for the router bridge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          noc_inject_packetizer_if.slave (request in, packet out)
//   err_pulse    one-cycle pulse after a dropped (illegal) request
//   fifo_level   current FIFO occupancy
//   sent_cnt, drop_cnt  saturating pop/drop counters (only with NOC_PKT_STATS_EN)
// Optional feature macro: NOC_PKT_STATS_EN.
module noc_inject_packetizer #(
  parameter int         WIDTH_PACKAGE = 33,
  parameter logic [4:0] ROUTER_LOC    = 5'b000_00,
  parameter int         DEPTH         = 4,
  parameter int         X_MAX         = 4,
  parameter int         Y_MAX         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  noc_inject_packetizer_if.slave     bus,
  output logic                       err_pulse,
`ifdef NOC_PKT_STATS_EN
  output logic [15:0]                sent_cnt,
  output logic [15:0]                drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (WIDTH_PACKAGE != 33) begin : g_bad_width
    $error("noc_inject_packetizer: WIDTH_PACKAGE must be 33");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("noc_inject_packetizer: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH_PACKAGE-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            count_q, count_d;
  logic                     ready_en_q;
  logic                     err_q, err_d;
  logic                     full, empty, accept, legal, push, pop;
  logic [WIDTH_PACKAGE-1:0] new_pkt;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);

  // ready_en_q keeps in_ready low through reset and up to the first edge after
  // release; in_ready never looks at pkt_ready, so a full FIFO refuses even
  // when it is being popped in the same cycle.
  assign bus.in_ready = ready_en_q && !full;
  assign accept       = bus.in_valid && bus.in_ready;

  assign legal = (bus.in_dest[4:2] <= X_MAX[2:0]) &&
                 (bus.in_dest[1:0] <= Y_MAX[1:0]) &&
                 (bus.in_dest != ROUTER_LOC);
  assign push  = accept && legal;
  assign pop   = !empty && bus.pkt_ready;

  assign new_pkt = {bus.in_dest, ROUTER_LOC, bus.in_type, bus.in_tag, bus.in_data};

  // pkt_data is forced to zero while empty so reset and drained states
  // present a clean bus; the entry itself comes straight from storage.
  assign bus.pkt_valid = !empty;
  assign bus.pkt_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_level    = count_q;
  assign err_pulse     = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = accept && !legal;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_pkt;
  end

`ifdef NOC_PKT_STATS_EN
  logic [15:0] sent_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop && sent_cnt_q != 16'hFFFF)       sent_cnt_q <= sent_cnt_q + 16'd1;
      if (err_d && drop_cnt_q != 16'hFFFF)     drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign sent_cnt = sent_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif
endmodule
